// File: rtl/icache_nway_if.sv
// CPU-side fetch, pmem-side line refill and status signals of the N-way instruction cache.
// The cache binds to the slave modport; the fetch stage/arbiter side binds to master.
interface icache_nway_if #(
  parameter int unsigned s_offset = 5
);
  localparam int unsigned s_line = 8 * 2**s_offset;

  logic [31:0]       mem_address;
  logic              mem_read;
  logic [31:0]       mem_rdata;
  logic              mem_resp;
  logic              flush;
  logic              flush_busy;
  logic [31:0]       pmem_address;
  logic              pmem_read;
  logic [s_line-1:0] pmem_rdata;
  logic              pmem_resp;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;

  modport master (
    output mem_address, mem_read, flush, pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, flush_busy, pmem_address, pmem_read, hit_count, miss_count
  );

  modport slave (
    input  mem_address, mem_read, flush, pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, flush_busy, pmem_address, pmem_read, hit_count, miss_count
  );
endinterface

// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with tree pseudo-LRU replacement,
// a whole-cache flush sweep and saturating hit/miss counters.
module icache_nway #(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_index  = 3,
  parameter int unsigned s_ways   = 2
) (
  input logic         clk,
  input logic         rst,
  icache_nway_if.slave bus
);
  localparam int unsigned num_sets = 2**s_index;
  localparam int unsigned num_ways = 2**s_ways;
  localparam int unsigned s_tag    = 32 - s_offset - s_index;
  localparam int unsigned s_line   = 8 * 2**s_offset;

  typedef enum logic [1:0] {StIdle, StCompare, StFill, StFlush} state_e;

  state_e              state_q, state_d;
  logic [31:2]         req_q, req_d;
  logic                flush_pend_q, flush_pend_d;
  logic [s_index-1:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0]         hit_q, miss_q;

  logic [num_ways-1:0] valid_q [num_sets];
  logic [num_ways-1:1] plru_q  [num_sets];
  logic [s_tag-1:0]    tag_q   [num_sets][num_ways];
  logic [s_line-1:0]   line_q  [num_sets][num_ways];

  logic [s_tag-1:0]    req_tag;
  logic [s_index-1:0]  idx;
  logic [s_offset-3:0] word_sel;
  logic [num_ways-1:0] match;
  logic                hit;
  logic [s_ways-1:0]   hit_way, victim;
  logic [num_ways-1:1] plru_upd;
  logic                hit_inc, miss_inc, fill_we, plru_we, flush_clr;

  assign req_tag  = req_q[31:s_offset+s_index];
  assign idx      = req_q[s_offset+s_index-1:s_offset];
  assign word_sel = req_q[s_offset-1:2];

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < num_ways; w++) begin
      match[w] = valid_q[idx][w] && (tag_q[idx][w] == req_tag);
      if (match[w]) hit_way = s_ways'(w);
    end
    hit = |match;
  end

  // Lowest invalid way first; only a full set consults the PLRU tree.
  always_comb begin
    int node;
    node   = 1;
    victim = '0;
    if (&valid_q[idx]) begin
      for (int l = 0; l < s_ways; l++) node = 2 * node + int'(plru_q[idx][s_ways'(node)]);
      victim = s_ways'(node - int'(num_ways));
    end else begin
      for (int w = num_ways - 1; w >= 0; w--) if (!valid_q[idx][w]) victim = s_ways'(w);
    end
  end

  always_comb begin
    int   node;
    logic dir;
    node     = 1;
    plru_upd = plru_q[idx];
    for (int l = 0; l < s_ways; l++) begin
      dir                      = hit_way[s_ways-1-l];
      plru_upd[s_ways'(node)]  = ~dir;
      node                     = 2 * node + int'(dir);
    end
  end

  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    flush_pend_d     = flush_pend_q;
    flush_cnt_d      = flush_cnt_q;
    bus.mem_resp     = 1'b0;
    bus.mem_rdata    = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_address = '0;
    hit_inc          = 1'b0;
    miss_inc         = 1'b0;
    fill_we          = 1'b0;
    plru_we          = 1'b0;
    flush_clr        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.flush || flush_pend_q) begin
          state_d      = StFlush;
          flush_cnt_d  = '0;
          flush_pend_d = 1'b0;
        end else if (bus.mem_read) begin
          req_d   = bus.mem_address[31:2];
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (bus.flush) flush_pend_d = 1'b1;
        if (hit) begin
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = line_q[idx][hit_way][{word_sel, 5'd0} +: 32];
          hit_inc       = 1'b1;
          plru_we       = 1'b1;
          state_d       = StIdle;
        end else begin
          miss_inc = 1'b1;
          state_d  = StFill;
        end
      end
      StFill: begin
        if (bus.flush) flush_pend_d = 1'b1;
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {req_q[31:s_offset], {s_offset{1'b0}}};
        if (bus.pmem_resp) begin
          fill_we = 1'b1;
          state_d = StCompare;
        end
      end
      StFlush: begin
        flush_clr   = 1'b1;
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == s_index'(num_sets - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.flush_busy = (state_q == StFlush) || flush_pend_q;
  assign bus.hit_count  = hit_q;
  assign bus.miss_count = miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      req_q        <= '0;
      flush_pend_q <= 1'b0;
      flush_cnt_q  <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      for (int s = 0; s < num_sets; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      flush_pend_q <= flush_pend_d;
      flush_cnt_q  <= flush_cnt_d;
      if (hit_inc && (hit_q != '1))   hit_q  <= hit_q + 32'd1;
      if (miss_inc && (miss_q != '1)) miss_q <= miss_q + 32'd1;
      if (fill_we) valid_q[idx][victim] <= 1'b1;
      if (plru_we) plru_q[idx] <= plru_upd;
      if (flush_clr) begin
        valid_q[flush_cnt_q] <= '0;
        plru_q[flush_cnt_q]  <= '0;
      end
    end
  end

  // Payload arrays carry no reset; a reset during a fill suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && fill_we) begin
      tag_q[idx][victim]  <= req_tag;
      line_q[idx][victim] <= bus.pmem_rdata;
    end
  end

  assert property (@(posedge clk) disable iff (rst) (state_q == StCompare) |-> $onehot0(match));

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway: scoreboarded fetches, PLRU replacement, flush and reset cases.
module tb_icache_nway;
  localparam int unsigned s_offset = 5;
  localparam int unsigned s_index  = 3;
  localparam int unsigned s_ways   = 2;
  localparam int unsigned s_line   = 8 * 2**s_offset;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_nway_if #(.s_offset(s_offset)) bus ();

  icache_nway #(
    .s_offset(s_offset),
    .s_index (s_index),
    .s_ways  (s_ways)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          exp_hit  = 0;
  int          exp_miss = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Backing memory: word k of line L is 0xA000_0000 + ((L ^ 2) << 8) + k.
  function automatic logic [31:0] word_of(input logic [31:0] addr);
    logic [31:0] l;
    l = (addr >> s_offset) ^ 32'h2;
    return 32'hA000_0000 + (l << 8) + 32'(addr[s_offset-1:2]);
  endfunction

  function automatic logic [s_line-1:0] line_of(input logic [31:0] addr);
    logic [s_line-1:0] line;
    logic [31:0]       a;
    for (int k = 0; k < 2**(s_offset-2); k++) begin
      a                = {addr[31:s_offset], 5'(k * 4)};
      line[k*32 +: 32] = word_of(a);
    end
    return line;
  endfunction

  // exp_pmem_k: cycle of first pmem_read after request (0 = hit); flush_at: cycle of flush pulse
  // (-1 none, 0 together with the request).
  task automatic do_read(input logic [31:0] addr, input int exp_pmem_k, input int flush_at,
                         input int resp_delay, output int busy_n);
    int k          = 0;
    int wait_cnt   = 0;
    int first_pmem = 0;
    bit done       = 0;
    busy_n = 0;
    exp_q.push_back(word_of(addr));
    bus.mem_address = addr;
    bus.mem_read    = 1'b1;
    if (flush_at == 0) bus.flush = 1'b1;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
      if (bus.flush) bus.flush = 1'b0;
      if (flush_at >= 0 && k == flush_at + 1) check("flush_busy_at_once", 32'(bus.flush_busy), 1);
      if (bus.flush_busy) busy_n++;
      if (bus.pmem_resp) begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
      end else if (bus.pmem_read) begin
        if (first_pmem == 0) begin
          first_pmem = k;
          check("pmem_address", bus.pmem_address, {addr[31:s_offset], 5'b0});
        end
        if (wait_cnt == resp_delay) begin
          bus.pmem_rdata = line_of(addr);
          bus.pmem_resp  = 1'b1;
        end else begin
          wait_cnt++;
        end
      end
      if (bus.mem_resp) begin
        if (exp_q.size() == 0) check("scoreboard_empty", 1, 0);
        else check("mem_rdata", bus.mem_rdata, exp_q.pop_front());
        bus.mem_read = 1'b0;
        done         = 1;
      end else begin
        check("mem_rdata_zero_without_resp", bus.mem_rdata, 0);
      end
      if (flush_at > 0 && k == flush_at) bus.flush = 1'b1;
    end
    if (!done) check("mem_resp_timeout", 0, 1);
    check("pmem_read_first_cycle", first_pmem, exp_pmem_k);
    exp_hit++;
    if (exp_pmem_k != 0) exp_miss++;
    @(negedge clk);
    if (bus.flush_busy) busy_n++;
    check("hit_count", bus.hit_count, exp_hit);
    check("miss_count", bus.miss_count, exp_miss);
  endtask

  task automatic count_busy(output int n);
    bit done = 0;
    n = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.flush_busy) n++;
      else done = 1;
    end
  endtask

  initial begin
    int b;
    int k;
    bit seen;
    rst             = 1'b1;
    bus.mem_address = '0;
    bus.mem_read    = 1'b0;
    bus.flush       = 1'b0;
    bus.pmem_rdata  = '0;
    bus.pmem_resp   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_mem_resp", 32'(bus.mem_resp), 0);
    check("reset_pmem_read", 32'(bus.pmem_read), 0);
    check("reset_flush_busy", 32'(bus.flush_busy), 0);
    check("reset_mem_rdata", bus.mem_rdata, 0);
    check("reset_pmem_address", bus.pmem_address, 0);
    check("reset_hit_count", bus.hit_count, 0);
    check("reset_miss_count", bus.miss_count, 0);

    // Cold miss then same-line hit.
    do_read(32'h0000_0040, 2, -1, 1, b);
    do_read(32'h0000_0044, 0, -1, 0, b);

    // Fill all four ways of set 0, re-hit way 0, then force PLRU replacement.
    do_read(32'h0000_0000, 2, -1, 0, b);
    do_read(32'h0000_0100, 2, -1, 2, b);
    do_read(32'h0000_0200, 2, -1, 0, b);
    do_read(32'h0000_0300, 2, -1, 1, b);
    do_read(32'h0000_0000, 0, -1, 0, b);
    do_read(32'h0000_0400, 2, -1, 0, b);
    do_read(32'h0000_0300, 0, -1, 0, b);
    do_read(32'h0000_0200, 2, -1, 0, b);
    do_read(32'h0000_0000, 0, -1, 0, b);
    do_read(32'h0000_0408, 0, -1, 0, b);

    // Flush during a fill: the fill finishes, then an 8-cycle sweep.
    do_read(32'h0000_0500, 2, 3, 3, b);
    count_busy(b);
    check("flush_sweep_cycles", b, 8);
    do_read(32'h0000_0040, 2, -1, 0, b);

    // Flush together with a request: sweep first, then the held request.
    do_read(32'h0000_0044, 11, 0, 1, b);
    check("flush_first_busy_cycles", b, 8);

    // Reset during a fill, with a late pmem_resp afterwards.
    bus.mem_address = 32'h0000_0080;
    bus.mem_read    = 1'b1;
    k    = 0;
    seen = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      seen = bus.pmem_read;
    end
    check("rst_fill_pmem_read_seen", 32'(seen), 1);
    rst          = 1'b1;
    bus.mem_read = 1'b0;
    @(negedge clk);
    rst            = 1'b0;
    check("rst_fill_pmem_read_dropped", 32'(bus.pmem_read), 0);
    check("rst_fill_no_resp", 32'(bus.mem_resp), 0);
    bus.pmem_rdata = line_of(32'h0000_0080);
    bus.pmem_resp  = 1'b1;
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    check("late_pmem_resp_no_resp", 32'(bus.mem_resp), 0);
    check("late_pmem_resp_hit_count", bus.hit_count, 0);
    check("late_pmem_resp_miss_count", bus.miss_count, 0);
    exp_hit  = 0;
    exp_miss = 0;
    do_read(32'h0000_0080, 2, -1, 0, b);
    do_read(32'h0000_0084, 0, -1, 0, b);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_nway.md
Name: icache_nway

Overview:
- Parametrised N-way set-associative read-only instruction cache. Successor to the 2-way icache.
- Generalises the number of ways, sets and line size. Replacement is tree pseudo-LRU.
- Adds a whole-cache flush (invalidate) sequencer and saturating hit/miss performance counters.
- Sits between the fetch stage (CPU side) and the line-wide memory arbiter (pmem side).

Parameters:
s_offset  5  byte-offset bits per line; line = 2**s_offset bytes
s_index  3  set-index bits; num_sets = 2**s_index
s_ways  2  log2 of associativity; num_ways = 2**s_ways, must be >= 2 (s_ways >= 1)
s_tag  32-s_offset-s_index  tag width (derived)
s_line  8*2**s_offset  line width in bits (derived)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
mem_address  in  32  fetch byte address; bits [1:0] ignored
mem_read  in  1  fetch request; held with address stable until mem_resp
mem_rdata  out  32  fetched word; valid only while mem_resp=1
mem_resp  out  1  one-cycle completion pulse
flush  in  1  single-cycle pulse requesting invalidation of all lines
flush_busy  out  1  high from flush acceptance until the sweep completes
pmem_address  out  32  line-aligned miss address (low s_offset bits = 0)
pmem_read  out  1  line read request; held until pmem_resp
pmem_rdata  in  s_line  returned line
pmem_resp  in  1  one-cycle line-return pulse
hit_count  out  32  saturating count of hit lookups
miss_count  out  32  saturating count of miss lookups

Behaviour:
- Address split:
  - tag = addr[31:s_offset+s_index]
  - index = addr[s_offset+s_index-1:s_offset]
  - word select = addr[s_offset-1:2]
- Storage: flip-flop arrays.
  - Per set and way: valid, tag and line.
  - Per set: num_ways-1 PLRU bits.
- Reset (sync):
  - All valid bits and PLRU bits cleared; counters cleared; flush pending cleared; state IDLE.
  - In the cycle after reset: mem_resp=0, pmem_read=0, flush_busy=0, mem_rdata=0, pmem_address=0.
  - Reset mid-FILL abandons the fill with no array write. A late pmem_resp arriving in IDLE is ignored.
- FSM: IDLE, COMPARE, FILL, FLUSH.
  - IDLE:
    - If flush or flush pending, go to FLUSH. Set counter = 0; flush_busy=1.
    - Else if mem_read, register mem_address into req_addr and go to COMPARE.
    - Flush has priority over mem_read. A request deferred this way is served after FLUSH, because the CPU keeps holding it.
  - COMPARE: compare req_addr tag against all valid ways of its set.
    - Hit:
      - mem_resp=1; mem_rdata = selected word.
      - Update PLRU for the hit way.
      - hit_count+1, saturating at 0xFFFFFFFF.
      - Go to IDLE.
    - Miss:
      - miss_count+1, saturating.
      - Go to FILL.
    - At most one way may match. Multi-match is an assertion error.
  - FILL:
    - pmem_read=1; pmem_address = {req_addr[31:s_offset], 0}.
    - On pmem_resp:
      - Write pmem_rdata, tag and valid=1 into the victim way.
      - Go to COMPARE, which then hits. The re-lookup counts as a hit, not a second miss.
      - PLRU is updated by that hit only.
  - FLUSH:
    - Each cycle, clear the valid bits of set[counter] in all ways and clear its PLRU bits.
    - When counter = num_sets-1, return to IDLE with flush_busy=0 next cycle.
    - Duration: num_sets cycles.
- Latency:
  - Hit: request sampled in IDLE at cycle T, mem_resp at T+1.
  - Miss: pmem_read from T+2; mem_resp in the cycle after pmem_resp.
  - Minimum request spacing is 2 cycles (IDLE, COMPARE).
- Flush arriving in COMPARE or FILL: latched as pending and flush_busy goes high immediately. The in-flight request completes normally, then FLUSH runs.
- Flush arriving while already in FLUSH: ignored; no restart.
- Victim selection:
  - The lowest-index invalid way of the set, if any.
  - Otherwise the tree-PLRU victim: heap-indexed nodes, root=1, bit=0 means victim is in the lower half.
- PLRU update on access to way w: every node on w's path is set to point away from w.
- mem_rdata is 0 whenever mem_resp=0.

Test Plan:
- Reset then read 0x0000_0040: miss. pmem_read=1 with pmem_address=0x0000_0040. Return line word[k]=0xA000_0000+k. mem_resp with rdata 0xA000_0000; miss_count=1, hit_count=1.
- Re-read 0x0000_0044 after that fill -> mem_resp exactly 1 cycle after sampling, rdata 0xA000_0001, no pmem_read, hit_count=2.
- s_ways=2, set 0: fill 0x000, 0x100, 0x200, 0x300 into ways 0-3. Re-hit 0x000. Then miss 0x400 -> replaces way 2 (address 0x200). A following read of 0x200 misses; a read of 0x000 hits.
- Assert flush while a miss is in FILL -> flush_busy=1 at once, the fill completes and responds, FLUSH lasts 8 cycles. A subsequent read of 0x040 misses again.
- Flush and mem_read asserted together in IDLE -> FLUSH runs first (8 cycles), then the held request is served with correct data.
- Assert rst while pmem_read=1, then deliver pmem_resp one cycle later -> no mem_resp, no array write, and a re-read of the same address misses.
